// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, FSM states and fixed constants for the SHA-256 block controller
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    UPDATE
  } state_t;

  localparam int NUM_ROUNDS = 64;
  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  // Packed with element 0 in the top word so H0 lands in [255:224].
  localparam word_t [0:7] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t [0:7] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

endpackage

// File: rtl/sha256_block_ctrl_if.sv
// rtl/sha256_block_ctrl_if.sv - block request, scheduler/core strobes and digest bus
// blk_sha224 exists only when SHA224_EN is defined.
interface sha256_block_ctrl_if;

  logic         blk_valid;
  logic         blk_first;
  logic         blk_ready;
`ifdef SHA224_EN
  logic         blk_sha224;
`endif
  logic         sched_load;
  logic         core_init;
  logic         round_en;
  logic [5:0]   round_idx;
  logic [255:0] work_in;
  logic [255:0] hash_state;
  logic         digest_valid;

  modport master (
    output blk_valid, blk_first,
`ifdef SHA224_EN
    output blk_sha224,
`endif
    output work_in,
    input  blk_ready, sched_load, core_init, round_en, round_idx, hash_state, digest_valid
  );

  modport slave (
    input  blk_valid, blk_first,
`ifdef SHA224_EN
    input  blk_sha224,
`endif
    input  work_in,
    output blk_ready, sched_load, core_init, round_en, round_idx, hash_state, digest_valid
  );

endinterface

// File: rtl/sha256_digest_add.sv
// rtl/sha256_digest_add.sv - eight independent mod-2^32 adds folding a..h into H0..H7
module sha256_digest_add
  import sha256_pkg::*;
(
  input  logic [255:0] hash_in,
  input  logic [255:0] work_in,
  output logic [255:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[32*i +: 32] = word_t'(hash_in[32*i +: 32] + work_in[32*i +: 32]);
    end
  end

endmodule

// File: rtl/sha256_block_ctrl.sv
// rtl/sha256_block_ctrl.sv - per-block sequencer: load, 64 rounds, fold into running digest
// SHA224_EN adds blk_sha224 to select the SHA-224 IV on a first block.
module sha256_block_ctrl
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sha256_block_ctrl_if.slave  bus
);

  state_t       state_q, state_d;
  logic [5:0]   round_idx_q, round_idx_d;
  logic [255:0] hash_q, hash_d;
  logic         digest_valid_q, digest_valid_d;
  logic [255:0] hash_sum;
  logic [255:0] iv_sel;
  logic         blk_ready, sched_load, core_init, round_en;

`ifdef SHA224_EN
  assign iv_sel = bus.blk_sha224 ? IV_224 : IV_256;
`else
  assign iv_sel = IV_256;
`endif

  sha256_digest_add u_add (
    .hash_in (hash_q),
    .work_in (bus.work_in),
    .sum     (hash_sum)
  );

  always_comb begin
    state_d        = state_q;
    round_idx_d    = round_idx_q;
    hash_d         = hash_q;
    digest_valid_d = 1'b0;
    blk_ready      = 1'b0;
    sched_load     = 1'b0;
    core_init      = 1'b0;
    round_en       = 1'b0;
    case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        if (bus.blk_valid) begin
          state_d = LOAD;
          if (bus.blk_first) hash_d = iv_sel;
        end
      end
      LOAD: begin
        sched_load  = 1'b1;
        core_init   = 1'b1;
        round_idx_d = '0;
        state_d     = ROUND;
      end
      ROUND: begin
        round_en = 1'b1;
        // Hold at the last round so the index never wraps before UPDATE.
        if (round_idx_q == LAST_ROUND) state_d = UPDATE;
        else round_idx_d = round_idx_q + 6'd1;
      end
      UPDATE: begin
        hash_d         = hash_sum;
        digest_valid_d = 1'b1;
        round_idx_d    = '0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      round_idx_q    <= '0;
      hash_q         <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_idx_q    <= round_idx_d;
      hash_q         <= hash_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign bus.blk_ready    = blk_ready;
  assign bus.sched_load   = sched_load;
  assign bus.core_init    = core_init;
  assign bus.round_en     = round_en;
  assign bus.round_idx    = round_idx_q;
  assign bus.hash_state   = hash_q;
  assign bus.digest_valid = digest_valid_q;

endmodule

// File: doc/sha256_block_ctrl.md
# sha256_block_ctrl

Per-block sequencer for the SHA-256 datapath. It accepts one 512-bit block request at a time and pulses the message scheduler load. It then steps the compression core through rounds 0..63 with a round index that drives the K-constant lookup. Finally it folds the core's working variables into the chained hash state H0..H7. It sits between the padding front-end and the message_scheduler / compression-core pair, and owns the only copy of the running digest.

## Interface
- No parameters; round count (64) and IV are fixed constants in the package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- blk_valid  in  1  block request; the block is already on message_scheduler data_in
- blk_first  in  1  qualifies blk_valid: first block of a message, so H is reinitialised to IV
- blk_ready  out  1  high in IDLE only; a block is accepted when blk_valid && blk_ready at a rising edge
- sched_load  out  1  one-cycle load pulse to message_scheduler
- core_init  out  1  core loads a..h from hash_state at the end of this cycle
- round_en  out  1  core performs one round this cycle
- round_idx  out  6  current round t, 0..63; selects K[t]
- work_in  in  256  core working variables {a,b,c,d,e,f,g,h}, a in [255:224]
- hash_state  out  256  running H0..H7, H0 in [255:224]
- digest_valid  out  1  one-cycle pulse: hash_state holds the result for the last accepted block

## Operation
- FSM states and transitions:
  - IDLE → LOAD on accept.
  - LOAD → ROUND unconditionally.
  - ROUND → UPDATE when round_idx == 63.
  - UPDATE → IDLE.
- IDLE:
  - blk_ready = 1; all other strobes 0.
  - On accept with blk_first = 1: hash_state ← IV.
  - On accept with blk_first = 0: hash_state is kept (chaining).
- LOAD: sched_load = 1, core_init = 1, round_idx = 0.
- ROUND:
  - round_en = 1.
  - round_idx increments each cycle, 0 → 63, and is never observed wrapping.
  - round_idx is cleared to 0 on UPDATE exit.
- UPDATE: hash_state[i] ← hash_state[i] + work_in[i] for each 32-bit word, modulo 2^32 per word. There is no carry between words.
- digest_valid is registered. It is high for exactly the first IDLE cycle after UPDATE.
- blk_valid is ignored outside IDLE. blk_first is sampled only at accept.
- A blk_valid arriving in the same cycle as digest_valid is accepted, giving back-to-back blocks.
- Reset, including mid-block:
  - Next cycle state = IDLE, blk_ready = 1.
  - sched_load, core_init, round_en and digest_valid = 0.
  - round_idx = 0, hash_state = 0.
  - A partially processed block is discarded; no digest_valid is produced for it.
- A chained block (blk_first = 0) accepted directly after reset chains from hash_state = 0. This is legal but meaningless, and the front-end must not do it.

## Timing
- Cycle numbering, with accept edge = end of cycle 0:
  - LOAD = cycle 1.
  - ROUND = cycles 2..65, with round_idx = t in cycle t+2.
  - UPDATE = cycle 66.
  - digest_valid and blk_ready are high in cycle 67.
- Minimum block-to-block period: 67 cycles.
- message_scheduler presents W[t] in cycle t+2, aligned with round_idx = t.
- work_in is sampled only at the end of UPDATE. It reflects the core after the round-63 update.

## Configuration
- SHA224_EN defined:
  - Adds input blk_sha224 (1 bit), sampled at accept together with blk_first.
  - blk_first with blk_sha224 = 1 loads the SHA-224 IV.
  - Sequencing is unchanged, and hash_state stays 256 bits; truncation to H0..H6 is done downstream.
- SHA224_EN undefined: port absent; the SHA-256 IV is always used.

## Structure
- Package sha256_pkg holds:
  - typedef word_t (32-bit).
  - The FSM state enum {IDLE, LOAD, ROUND, UPDATE}.
  - The localparams IV_256[0:7], IV_224[0:7] and NUM_ROUNDS = 64.
- Sub-module sha256_digest_add: eight parallel 32-bit modulo adders, hash_state + work_in. It is combinational; the controller registers its result in UPDATE.
- The round counter and FSM stay in the top module.

## Test plan
- Reset, then idle:
  - Required: blk_ready = 1, hash_state = 0, round_idx = 0, all strobes 0.
- "abc" single block, blk_first = 1, real message_scheduler plus core:
  - Required: sched_load in cycle 1, round_en in cycles 2..65, digest_valid in cycle 67.
  - Required: hash_state = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", two blocks (second with blk_first = 0), back-to-back with blk_valid held:
  - Required: second accept on the digest_valid cycle.
  - Required: final hash_state = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- rst asserted at round_idx = 30, then "abc" restarted:
  - Required: no digest_valid for the aborted block.
  - Required: the restarted block gives the correct "abc" digest.
- blk_valid pulsed during ROUND:
  - Required: no accept, and round_idx progression unaffected.
- With SHA224_EN, "abc" with blk_sha224 = 1:
  - Required: hash_state[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
